// File: rtl/viterbi_puncture.sv
// Transmit-side puncturer: drops encoder bits per keep-patterns and repacks survivors
// into 2-bit words with valid/ready handshakes on both sides.
module viterbi_puncture #(
  parameter int unsigned                 p_speed_size = 1,
  parameter logic [p_speed_size-1:0]     p_speed_pol0 = p_speed_size'(1'b1),
  parameter logic [p_speed_size-1:0]     p_speed_pol1 = p_speed_size'(1'b1)
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [1:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       o_ready,
  input  logic [7:0] i_speed,
  output logic [1:0] o_data,
  output logic [1:0] o_mask,
  output logic       o_valid,
  output logic       o_last,
  input  logic       i_ready
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned BUF_W = 3;
  localparam logic [IDX_W-1:0] SIZE8 = IDX_W'(p_speed_size);

  // Patterns widened to the full index range so any r_idx is a legal select.
  localparam logic [255:0] PAT0 = 256'(p_speed_pol0);
  localparam logic [255:0] PAT1 = 256'(p_speed_pol1);

  logic [IDX_W-1:0] r_idx, idx_nxt;
  logic [BUF_W-1:0] r_buf, buf_nxt;
  logic [1:0]       r_cnt, cnt_nxt;
  logic             r_flush, flush_nxt;

  logic [IDX_W-1:0] period;
  logic             k0, k1;
  logic [1:0]       comp;
  logic [1:0]       nk;
  logic [1:0]       pop;
  logic [1:0]       base;
  logic             in_fire, out_fire;

  // State registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_idx   <= '0;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_flush <= 1'b0;
    end else begin
      r_idx   <= idx_nxt;
      r_buf   <= buf_nxt;
      r_cnt   <= cnt_nxt;
      r_flush <= flush_nxt;
    end
  end

  // Effective period: 0 behaves as 1, oversize clamps to the pattern length.
  always_comb begin
    period = i_speed;
    if (i_speed == '0) begin
      period = IDX_W'(1);
    end else if (i_speed > SIZE8) begin
      period = SIZE8;
    end
  end

  // Compact kept bits, G0 first.
  always_comb begin
    k0   = PAT0[r_idx];
    k1   = PAT1[r_idx];
    comp = '0;
    if (k0) begin
      comp = {k1 & i_data[1], i_data[0]};
    end else begin
      comp = {1'b0, k1 & i_data[1]};
    end
    nk = 2'({1'b0, k0}) + 2'({1'b0, k1});
  end

  assign in_fire  = i_valid && o_ready;
  assign out_fire = o_valid && i_ready;

  // Next-state: pop before push, pattern index advance, flush tracking.
  always_comb begin
    pop       = '0;
    idx_nxt   = r_idx;
    flush_nxt = r_flush;
    if (out_fire) begin
      pop = (r_cnt >= 2'd2) ? 2'd2 : r_cnt;
    end
    base    = r_cnt - pop;
    buf_nxt = (r_buf >> pop) | (in_fire ? (BUF_W'(comp) << base) : BUF_W'(0));
    cnt_nxt = base + (in_fire ? nk : 2'd0);
    if (in_fire) begin
      if (i_last || (r_idx >= IDX_W'(period - IDX_W'(1)))) begin
        idx_nxt = '0;
      end else begin
        idx_nxt = IDX_W'(r_idx + IDX_W'(1));
      end
    end
    if (in_fire && i_last) begin
      flush_nxt = 1'b1;
    end else if (out_fire && o_last) begin
      flush_nxt = 1'b0;
    end
  end

  // Output decode from buffer occupancy and flush flag.
  always_comb begin
    o_mask = 2'b00;
    if (r_cnt >= 2'd2) begin
      o_mask = 2'b11;
    end else if (r_cnt == 2'd1) begin
      o_mask = 2'b01;
    end
    o_data  = r_buf[1:0] & o_mask;
    o_valid = (r_cnt >= 2'd2) || r_flush;
    o_last  = r_flush && (r_cnt <= 2'd2);
    o_ready = i_reset_n && !r_flush && ((r_cnt <= 2'd1) || i_ready);
  end

endmodule

// File: tb/tb_viterbi_puncture.sv
// Self-checking bench for viterbi_puncture: bit-list reference model,
// directed rate cases, backpressure, reset and randomized frames.
module tb_viterbi_puncture;

  localparam int unsigned SIZE = 4;
  localparam logic [3:0]  POL0 = 4'b0011;
  localparam logic [3:0]  POL1 = 4'b0101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] i_data;
  logic       i_valid;
  logic       i_last;
  logic       o_ready;
  logic [7:0] i_speed;
  logic [1:0] o_data;
  logic [1:0] o_mask;
  logic       o_valid;
  logic       o_last;
  logic       i_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] syms[$];

  always #5 clk = ~clk;

  viterbi_puncture #(
    .p_speed_size(SIZE),
    .p_speed_pol0(POL0),
    .p_speed_pol1(POL1)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .i_last   (i_last),
    .o_ready  (o_ready),
    .i_speed  (i_speed),
    .o_data   (o_data),
    .o_mask   (o_mask),
    .o_valid  (o_valid),
    .o_last   (o_last),
    .i_ready  (i_ready)
  );

  function automatic int eff_period(input logic [7:0] s);
    if (s == 8'd0) return 1;
    if (int'(s) > int'(SIZE)) return int'(SIZE);
    return int'(s);
  endfunction

  function automatic int kept_count(input int pos);
    logic [3:0] p0, p1;
    p0 = POL0;
    p1 = POL1;
    return int'(p0[pos]) + int'(p1[pos]);
  endfunction

  // Drives the frame in syms[] and checks every cycle against the reference.
  // vmode: 0 = dense valid, 1 = random gaps. rmode: 0 = always ready,
  // 1 = random ready, 2 = ready dropped for cycles 4..8.
  task automatic run_frame(input string name, input logic [7:0] speed,
                           input int vmode, input int rmode);
    int         per, n, total, nk_last, fc, full, si, ew, mcnt, cyc, pop;
    logic       flushing, done, exp_valid, exp_ready, in_f, out_f;
    logic       bits[$];
    logic [4:0] exp_q[$];
    logic [4:0] got;
    logic [3:0] p0, p1;
    p0 = POL0;
    p1 = POL1;
    per = eff_period(speed);
    n = syms.size();
    nk_last = 0;
    for (int i = 0; i < n; i++) begin
      int pos;
      int nk;
      logic [1:0] s;
      pos = i % per;
      s = syms[i];
      nk = 0;
      if (p0[pos]) begin bits.push_back(s[0]); nk++; end
      if (p1[pos]) begin bits.push_back(s[1]); nk++; end
      nk_last = nk;
    end
    total = bits.size();
    fc = ((total - nk_last) % 2) + nk_last;
    full = total - fc;
    for (int j = 0; j < full; j += 2)
      exp_q.push_back({1'b0, 2'b11, bits[j+1], bits[j]});
    case (fc)
      0: exp_q.push_back({1'b1, 2'b00, 2'b00});
      1: exp_q.push_back({1'b1, 2'b01, 1'b0, bits[full]});
      2: exp_q.push_back({1'b1, 2'b11, bits[full+1], bits[full]});
      default: begin
        exp_q.push_back({1'b0, 2'b11, bits[full+1], bits[full]});
        exp_q.push_back({1'b1, 2'b01, 1'b0, bits[full+2]});
      end
    endcase

    i_speed = speed;
    si = 0; ew = 0; mcnt = 0; cyc = 0;
    flushing = 1'b0; done = 1'b0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      i_valid = (si < n) && (vmode == 0 || $urandom_range(0, 3) != 0);
      i_data  = (si < n) ? syms[si] : 2'b00;
      i_last  = i_valid && (si == n - 1);
      case (rmode)
        0: i_ready = 1'b1;
        1: i_ready = ($urandom_range(0, 2) != 0);
        default: i_ready = !(cyc >= 4 && cyc < 9);
      endcase
      #1;
      exp_valid = (mcnt >= 2) || flushing;
      exp_ready = !flushing && (mcnt <= 1 || i_ready);
      n_checks++;
      if (o_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL %s o_ready cyc=%0d got=%b want=%b", name, cyc, o_ready, exp_ready);
      end
      n_checks++;
      if (o_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL %s o_valid cyc=%0d got=%b want=%b", name, cyc, o_valid, exp_valid);
      end
      if (o_valid && ew < exp_q.size()) begin
        got = {o_last, o_mask, o_data};
        n_checks++;
        if (got !== exp_q[ew]) begin
          n_fail++;
          $display("FAIL %s word%0d cyc=%0d got last/mask/data=%b want=%b",
                   name, ew, cyc, got, exp_q[ew]);
        end
      end
      in_f  = i_valid && exp_ready;
      out_f = exp_valid && i_ready;
      if (out_f) begin
        pop = (mcnt >= 2) ? 2 : mcnt;
        mcnt -= pop;
        if (ew < exp_q.size()) begin
          if (exp_q[ew][4]) begin
            done = 1'b1;
            flushing = 1'b0;
          end
        end
        ew++;
      end
      if (in_f) begin
        mcnt += kept_count(si % per);
        if (i_last) flushing = 1'b1;
        si++;
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    n_checks++;
    if (!done || ew != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s frame_end got words=%0d done=%b want words=%0d",
               name, ew, done, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_data = 2'b00;
    i_ready = 1'b1; i_speed = 8'd1;
    #1;
    n_checks++;
    if ({o_data, o_mask, o_valid, o_last, o_ready} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=0000000",
               {o_data, o_mask, o_valid, o_last, o_ready});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({o_data, o_mask, o_valid, o_last, o_ready} !== 7'b0000001) begin
      n_fail++;
      $display("FAIL after_reset got=%b want=0000001",
               {o_data, o_mask, o_valid, o_last, o_ready});
    end
  endtask

  task automatic test_rate_half();
    syms = '{2'b10, 2'b01};
    run_frame("rate_1_2", 8'd1, 0, 0);
  endtask

  task automatic test_rate_three_quarter();
    syms = '{2'b10, 2'b01, 2'b10};
    run_frame("rate_3_4", 8'd3, 0, 0);
  endtask

  task automatic test_rate_two_third();
    syms = '{2'b11, 2'b11, 2'b11};
    run_frame("rate_2_3", 8'd2, 0, 0);
  endtask

  task automatic test_backpressure();
    syms = {};
    for (int i = 0; i < 12; i++) syms.push_back(2'($urandom_range(0, 3)));
    run_frame("backpressure", 8'd1, 0, 2);
  endtask

  task automatic test_full_puncture();
    syms = '{2'b11, 2'b10, 2'b01, 2'b11};
    run_frame("full_puncture", 8'd4, 0, 0);
  endtask

  task automatic test_reset_mid_frame();
    i_speed = 8'd3; i_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b1; i_data = 2'b11; i_last = 1'b0;
    @(negedge clk);
    i_data = 2'b01;
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    n_checks++;
    if ({o_valid, o_mask, o_data} !== 5'b00101) begin
      n_fail++;
      $display("FAIL mid_frame_cnt1 got valid/mask/data=%b want=00101",
               {o_valid, o_mask, o_data});
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_data, o_mask, o_valid, o_last, o_ready} !== 7'b0) begin
      n_fail++;
      $display("FAIL mid_frame_reset got=%b want=0000000",
               {o_data, o_mask, o_valid, o_last, o_ready});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    syms = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
    run_frame("after_mid_reset", 8'd3, 0, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      int len;
      len = int'($urandom_range(1, 12));
      syms = {};
      for (int i = 0; i < len; i++) syms.push_back(2'($urandom_range(0, 3)));
      run_frame($sformatf("random%0d", f), 8'($urandom_range(0, 9)), 1, 1);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 8; f++) begin
      int len;
      len = int'($urandom_range(1, 10));
      syms = {};
      for (int i = 0; i < len; i++) syms.push_back(2'($urandom_range(0, 3)));
      run_frame($sformatf("b2b%0d", f), 8'($urandom_range(1, 4)), 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_rate_half();
    test_rate_three_quarter();
    test_rate_two_third();
    test_backpressure();
    test_full_puncture();
    test_reset_mid_frame();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/viterbi_puncture.md
# viterbi_puncture

Transmit-side puncturer for the rate-1/2 convolutional encoder path. It accepts one 2-bit encoder symbol per handshake ({G1,G0}) and deletes bits according to two per-polynomial puncture patterns. It packs the surviving bits, in transmission order, into 2-bit output words with a valid/ready handshake. It sits between the convolutional encoder and the modulator mapper and produces the punctured stream that the receive-side speed/depuncture map reconstructs.

## Interface
- p_speed_size, 1: puncture period length in symbols (1..255); width of the pattern parameters.
- p_speed_pol0, 1'b1: keep-pattern for G0 (bit 0); bit i = 1 keeps G0 at pattern position i; LSB is first in time.
- p_speed_pol1, 1'b1: keep-pattern for G1 (bit 1); same encoding as p_speed_pol0.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_data  in  2  encoder symbol, [0]=G0, [1]=G1.
- i_valid  in  1  i_data/i_last valid.
- i_last  in  1  marks the final symbol of a frame.
- o_ready  out  1  block accepts input this cycle.
- i_speed  in  8  active period length; 0 is treated as 1, and values > p_speed_size are treated as p_speed_size; must be stable within a frame.
- o_data  out  2  packed punctured bits, [0] is first in time.
- o_mask  out  2  which o_data bits are real: 11 full, 01 half (flush), 00 empty terminator.
- o_valid  out  1  output word valid.
- o_last  out  1  final word of the frame.
- i_ready  in  1  downstream accepts the output word.

## Operation
- State: r_idx (8 b) pattern position; r_buf (3 b) bit FIFO, bit 0 oldest; r_cnt (2 b, 0..3) buffered bits; r_flush (1 b).
- Input fire: i_valid && o_ready. Output fire: o_valid && i_ready.
- Keep bits at input fire: k0 = p_speed_pol0[r_idx], k1 = p_speed_pol1[r_idx]. The kept bits are compacted in order G0 then G1, giving nk ∈ {0,1,2}. If only G1 is kept, it occupies compacted position 0.
- r_idx: increments on input fire; wraps to 0 when r_idx >= period-1; forced to 0 on an input fire with i_last.
- Pop count pop = output fire ? min(r_cnt,2) : 0.
- Buffer update per cycle: r_buf ← (r_buf >> pop) | (compacted << (r_cnt-pop)) when an input fires; r_cnt ← r_cnt - pop + nk. Bits above r_cnt are don't-care but are held at 0.
- o_data = r_buf[1:0] masked by o_mask.
- o_valid = (r_cnt >= 2) || r_flush.
- o_mask = 11 if r_cnt >= 2, 01 if r_cnt == 1, 00 if r_cnt == 0.
- o_last = r_flush && (r_cnt <= 2).
- o_ready = i_reset_n && !r_flush && (r_cnt <= 1 || i_ready). This is combinational from i_ready, which allows sustained full rate with a 2-bit pop plus a 2-bit push (max occupancy 3).
- Flush: an input fire with i_last sets r_flush in the following cycle. r_flush clears on an output fire with o_last. New input is blocked while r_flush = 1.
- Frame fully punctured with an empty buffer: a single terminator word is emitted (o_valid=1, o_mask=00, o_last=1).
- r_cnt == 3 at flush: emit a full word (o_last=0), then a 01 word with o_last=1.
- Holding: while o_valid && !i_ready, o_data, o_mask and o_last stay stable.

## Timing
- Reset (asynchronous assert, synchronous release) clears r_idx, r_buf, r_cnt and r_flush.
- Output values in and after reset: o_data=00, o_mask=00, o_valid=0, o_last=0; o_ready=0 while i_reset_n is low, and 1 afterwards.
- Latency: bits accepted at edge k appear on o_data after edge k (valid in cycle k+1) when r_cnt reaches 2.
- Throughput:
  - With an all-ones pattern: one output word per cycle.
  - At a punctured rate: the input is never stalled while i_ready = 1 (except during flush).
- Reset mid-frame discards buffered bits and the pattern phase; the next accepted symbol uses pattern position 0.
- Simultaneous input and output fire is legal; the pop is applied before the push.

## Test plan
- Rate 1/2 (p_speed_size=1, both patterns 1'b1, i_speed=1), input 2'b10, 2'b01 with i_ready=1 -> outputs 2'b10, 2'b01 with o_mask=11, one per cycle, o_ready held at 1.
- Rate 3/4 (p_speed_size=3, pol0=3'b011, pol1=3'b101, i_speed=3), inputs 2'b10, 2'b01, 2'b10 with the last one carrying i_last -> kept bit order 0,1,1,1 -> outputs 2'b10 then 2'b11, the second with o_last=1 and o_mask=11.
- Rate 2/3 (pol0=2'b11, pol1=2'b01, i_speed=2), 3 symbols all 2'b11 with i_last on the 3rd -> 5 kept bits -> words 11, 11, then 2'b01 with o_mask=01 and o_last=1.
- Backpressure: i_ready=0 for 5 cycles during rate 1/2 streaming -> o_ready falls once r_cnt ≥ 2, o_data is stable, and no bits are lost or duplicated after i_ready returns.
- Fully punctured last symbol with an empty buffer (pattern position where pol0=pol1=0) -> a single word with o_valid=1, o_mask=00, o_last=1.
- Assert i_reset_n=0 mid-frame with r_cnt=1 -> outputs immediately take their reset values; after release, the first symbol uses pattern position 0.
